// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one 32-bit synchronous data-memory word port
// between port 0 (CPU LSU) and port 1 (loader/DMA). Each access runs as a
// multi-cycle transaction; loads get lane extraction plus sign/zero
// extension, and sub-word stores are done as read-modify-write.
// Optional feature macro: RR_ARB_EN (round-robin arbitration instead of
// fixed priority with port 0 first).
module dmem_port_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic [1:0]        size0_i,
  input  logic              uns0_i,
  output logic              ack0_o,
  output logic              err0_o,
  output logic [31:0]       rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  input  logic [1:0]        size1_i,
  input  logic              uns1_i,
  output logic              ack1_o,
  output logic              err1_o,
  output logic [31:0]       rdata1_o,
  output logic              busy_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Misaligned half/word or the reserved size code: no memory access is made.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte/half lane out of a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overwrite the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] a, input logic [1:0] size);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: begin
        case (a)
          2'b00:   r[7:0]   = d[7:0];
          2'b01:   r[15:8]  = d[7:0];
          2'b10:   r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) begin
          r[31:16] = d[15:0];
        end else begin
          r[15:0] = d[15:0];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [31:0]       data_q, data_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              avail0_s, avail1_s, grant0_s, grant1_s;
  logic              sel_we_s, sel_uns_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic [1:0]        sel_size_s;
  logic              sel_bad_s;

  // A port whose ack is still visible is masked so the same request is not served twice.
  assign avail0_s = req0_i & ~ack0_q;
  assign avail1_s = req1_i & ~ack1_q;

`ifdef RR_ARB_EN
  logic last_grant_q, last_grant_d;
  assign grant1_s = avail1_s & (~avail0_s | ~last_grant_q);

  // Remember which port received the most recent grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == S_IDLE) && (grant0_s || grant1_s)) begin
      last_grant_d = grant1_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin history flop; port 1 counts as last so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant1_s = avail1_s & ~avail0_s;
`endif
  assign grant0_s = avail0_s & ~grant1_s;

  assign sel_we_s    = grant1_s ? we1_i    : we0_i;
  assign sel_addr_s  = grant1_s ? addr1_i  : addr0_i;
  assign sel_wdata_s = grant1_s ? wdata1_i : wdata0_i;
  assign sel_size_s  = grant1_s ? size1_i  : size0_i;
  assign sel_uns_s   = grant1_s ? uns1_i   : uns0_i;
  assign sel_bad_s   = access_bad(sel_size_s, sel_addr_s[1:0]);

  // Transaction sequencer: next state, latched request and next memory-port values.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    data_d      = data_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant0_s || grant1_s) begin
          port_d  = grant1_s;
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          size_d  = sel_size_s;
          uns_d   = sel_uns_s;
          err_d   = sel_bad_s;
          if (sel_bad_s) begin
            state_d = S_DONE;
          end else if (sel_we_s && (sel_size_s == 2'b10)) begin
            state_d     = S_WR;
            data_d      = sel_wdata_s;
            mem_we_d    = 1'b1;
            mem_addr_d  = sel_addr_s[ADDR_W-1:2];
            mem_wdata_d = sel_wdata_s;
          end else begin
            state_d    = S_RD;
            mem_addr_d = sel_addr_s[ADDR_W-1:2];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_MERGE;
      end
      S_MERGE: begin
        if (we_q) begin
          data_d      = store_merge(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
          state_d     = S_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
        end else begin
          data_d  = load_extract(mem_rdata_i, addr_q[1:0], size_q, uns_q);
          state_d = S_DONE;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (port_q) begin
          ack1_d   = 1'b1;
          err1_d   = err_q;
          rdata1_d = (!we_q && !err_q) ? data_q : 32'h0000_0000;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = err_q;
          rdata0_d = (!we_q && !err_q) ? data_q : 32'h0000_0000;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction and drops mem_we at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= 32'h0000_0000;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'h0000_0000;
      rdata1_q    <= 32'h0000_0000;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      data_q      <= data_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack0_o      = ack0_q;
  assign err0_o      = err0_q;
  assign rdata0_o    = rdata0_q;
  assign ack1_o      = ack1_q;
  assign err1_o      = err1_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = busy_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1-cycle-latency
// word memory. Inputs change on the falling edge, outputs are sampled there.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, uns0, req1, we1, uns1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        ack0, err0, ack1, err1, busy, mem_we;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [13:0] mem_addr;

  logic [31:0] mem [0:16383];
  int          we_cnt;
  logic [13:0] last_we_addr;
  logic [31:0] last_we_data;
  int          errors;
  int          checks;

  dmem_port_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .size0_i(size0), .uns0_i(uns0),
    .ack0_o(ack0), .err0_o(err0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .size1_i(size1), .uns1_i(uns1),
    .ack1_o(ack1), .err1_o(err1), .rdata1_o(rdata1),
    .busy_o(busy), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous word memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Record every write-enable cycle seen on the memory port.
  initial we_cnt = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Run one transaction on port p; lat = cycles from grant edge to ack, -1 on timeout.
  task automatic run_txn(input int p, input logic we, input logic [15:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic un,
                         output int lat, output logic er, output logic [31:0] rd);
    int   cyc;
    logic got;
    if (p == 0) begin
      we0 = we; addr0 = a; wdata0 = wd; size0 = sz; uns0 = un; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = a; wdata1 = wd; size1 = sz; uns1 = un; req1 = 1'b1;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    lat = got ? cyc - 1 : -1;
    er  = (p == 0) ? err0 : err1;
    rd  = (p == 0) ? rdata0 : rdata1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 14'h0000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (rdata0 !== 32'h0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_port0 got=%h/%b exp=0/0", rdata0, err0); end
    checks++; if (rdata1 !== 32'h0 || err1 !== 1'b0) begin errors++; $display("FAIL reset_port1 got=%h/%b exp=0/0", rdata1, err1); end
  endtask

  task automatic test_store_word();
    int lat; logic er; logic [31:0] rd; int w0;
    w0 = we_cnt;
    run_txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 2'b10, 1'b0, lat, er, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err got=%b exp=0", er); end
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL sw_we_pulses got=%0d exp=1", we_cnt - w0); end
    checks++; if (last_we_addr !== 14'h0004) begin errors++; $display("FAIL sw_addr got=%h exp=0004", last_we_addr); end
    checks++; if (last_we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got=%h exp=deadbeef", last_we_data); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL sw_ack_pulse got=%b exp=0", ack0); end
    checks++; if (mem_addr !== 14'h0004 || mem_we !== 1'b0) begin errors++; $display("FAIL sw_port_hold got=%h/%b exp=0004/0", mem_addr, mem_we); end
  endtask

  task automatic test_store_byte();
    int lat; logic er; logic [31:0] rd; int w0;
    w0 = we_cnt;
    run_txn(0, 1'b1, 16'h0012, 32'h00000055, 2'b00, 1'b0, lat, er, rd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency got=%0d exp=4", lat); end
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL sb_we_pulses got=%0d exp=1", we_cnt - w0); end
    checks++; if (last_we_data !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_merged got=%h exp=de55beef", last_we_data); end
    run_txn(0, 1'b0, 16'h0012, 32'h0, 2'b00, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL lb_0012 got=%h exp=00000055", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", lat); end
    run_txn(0, 1'b0, 16'h0013, 32'h0, 2'b00, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_0013_sext got=%h exp=ffffffde", rd); end
    run_txn(0, 1'b0, 16'h0010, 32'h0, 2'b00, 1'b1, lat, er, rd);
    checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu_0010 got=%h exp=000000ef", rd); end
  endtask

  task automatic test_load_half();
    int lat; logic er; logic [31:0] rd;
    run_txn(0, 1'b0, 16'h0012, 32'h0, 2'b01, 1'b1, lat, er, rd);
    checks++; if (rd !== 32'h0000DE55) begin errors++; $display("FAIL lhu_0012 got=%h exp=0000de55", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lh_latency got=%0d exp=3", lat); end
    run_txn(0, 1'b0, 16'h0012, 32'h0, 2'b01, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'hFFFFDE55) begin errors++; $display("FAIL lh_0012_sext got=%h exp=ffffde55", rd); end
    run_txn(0, 1'b0, 16'h0010, 32'h0, 2'b01, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_0010_sext got=%h exp=ffffbeef", rd); end
    run_txn(0, 1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'hDE55BEEF) begin errors++; $display("FAIL lw_0010 got=%h exp=de55beef", rd); end
  endtask

  task automatic test_error();
    int lat; logic er; logic [31:0] rd; int w0;
    w0 = we_cnt;
    run_txn(0, 1'b0, 16'h0011, 32'h0, 2'b10, 1'b0, lat, er, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_lw_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_lw_flag got=%b exp=1", er); end
    run_txn(0, 1'b1, 16'h0013, 32'h0000AAAA, 2'b01, 1'b0, lat, er, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_sh_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_sh_flag got=%b exp=1", er); end
    run_txn(1, 1'b1, 16'h0010, 32'h12345678, 2'b11, 1'b0, lat, er, rd);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_size11 got=%b/%0d exp=1/1", er, lat); end
    checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL err_no_write got=%0d exp=0", we_cnt - w0); end
    run_txn(0, 1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, lat, er, rd);
    checks++; if (er !== 1'b0 || rd !== 32'hDE55BEEF) begin errors++; $display("FAIL err_mem_intact got=%b/%h exp=0/de55beef", er, rd); end
  endtask

  task automatic test_arbitration();
    int   exp_first;
    int   first;
    int   cyc;
    logic seen0, seen1;
    logic last_model;
    reset_dut();
    last_model = 1'b1;
    for (int r = 0; r < 4; r++) begin
`ifdef RR_ARB_EN
      exp_first = last_model ? 0 : 1;
`else
      exp_first = 0;
`endif
      we0 = 1'b0; addr0 = 16'h0010; size0 = 2'b10; uns0 = 1'b0;
      we1 = 1'b0; addr1 = 16'h0012; size1 = 2'b01; uns1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      first = -1; seen0 = 1'b0; seen1 = 1'b0; cyc = 0;
      while (!(seen0 && seen1) && cyc < 40) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ack0 && !seen0) begin
          seen0 = 1'b1; req0 = 1'b0;
          if (first < 0) first = 0;
          checks++; if (rdata0 !== 32'hDE55BEEF) begin errors++; $display("FAIL arb_rdata0 r=%0d got=%h exp=de55beef", r, rdata0); end
        end
        if (ack1 && !seen1) begin
          seen1 = 1'b1; req1 = 1'b0;
          if (first < 0) first = 1;
          checks++; if (rdata1 !== 32'h0000DE55) begin errors++; $display("FAIL arb_rdata1 r=%0d got=%h exp=0000de55", r, rdata1); end
        end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      checks++; if (!(seen0 && seen1)) begin errors++; $display("FAIL arb_both_served r=%0d got=%b%b exp=11", r, seen0, seen1); end
      checks++; if (first !== exp_first) begin errors++; $display("FAIL arb_first r=%0d got=%0d exp=%0d", r, first, exp_first); end
      last_model = (exp_first == 0) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic er; logic [31:0] rd; int cyc;
    we0 = 1'b1; addr0 = 16'h0010; wdata0 = 32'h00000077; size0 = 2'b00; uns0 = 1'b0; req0 = 1'b1;
    cyc = 0;
    while (mem_we !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_reach_wr got=%b exp=1", mem_we); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we_async got=%b exp=0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    req0 = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rst_no_ack got=%b exp=0", ack0); end
    end
    run_txn(0, 1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, lat, er, rd);
    checks++; if (rd !== 32'hDE55BEEF || lat !== 3) begin errors++; $display("FAIL rst_next_txn got=%h/%0d exp=de55beef/3", rd, lat); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 32'h0; size0 = 2'b00; uns0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 32'h0; size1 = 2'b00; uns1 = 1'b0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_half();
    test_error();
    test_arbitration();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
